// File: rtl/seq_detect_moore.sv
// Runtime-programmable Moore serial pattern detector with overlap control
// and a saturating match counter.
module seq_detect_moore #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN+1),
  parameter int CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b01,
  parameter logic [LEN_W-1:0]   DEF_LEN     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               a,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clear_cnt,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  typedef enum logic [1:0] {FILL, HUNT, HIT} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] hist, pat;
  logic [LEN_W-1:0]   fill, len;
  logic               ovl;

  logic [MAX_LEN-1:0] hist_nx, mask;
  logic [MAX_LEN:0]   mask_full;
  logic [LEN_W-1:0]   fill_nx;
  logic               len_ok, cfg_len_ok, match, hit_entry;

  assign len_ok     = (len != '0) && (len <= LEN_W'(MAX_LEN));
  assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign hist_nx    = {hist[MAX_LEN-2:0], a};
  assign fill_nx    = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
  // Mask is only meaningful for legal lengths; match is gated by len_ok.
  assign mask_full  = ({{MAX_LEN{1'b0}}, 1'b1} << len) - 1'b1;
  assign mask       = mask_full[MAX_LEN-1:0];
  assign match      = len_ok && (fill_nx >= len) && (((hist_nx ^ pat) & mask) == '0);
  assign hit_entry  = !cfg_load && en && match;
  assign y          = (state == HIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FILL;
      hist    <= '0;
      fill    <= '0;
      pat     <= DEF_PATTERN;
      len     <= DEF_LEN;
      ovl     <= 1'b1;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      // A bit arriving on the load edge is dropped along with the history.
      state   <= FILL;
      hist    <= '0;
      fill    <= '0;
      pat     <= cfg_pattern;
      len     <= cfg_len;
      ovl     <= cfg_overlap;
      cfg_err <= !cfg_len_ok;
    end else if (en) begin
      hist <= hist_nx;
      fill <= (match && !ovl) ? '0 : fill_nx;
      if (match)                          state <= HIT;
      else if (len_ok && fill_nx >= len)  state <= HUNT;
      else                                state <= FILL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      match_cnt <= '0;
    else if (clear_cnt)
      match_cnt <= hit_entry ? CNT_W'(1) : '0;
    else if (hit_entry && match_cnt != '1)
      match_cnt <= match_cnt + 1'b1;
  end

endmodule

// File: tb/tb_seq_detect_moore.sv
// Directed bench for seq_detect_moore: defaults, overlap modes, en gating,
// config corner cases and counter saturation/clear.
module tb_seq_detect_moore;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk = 0, reset = 0, en = 0, a = 0;
  logic               cfg_load = 0, cfg_overlap = 0, clear_cnt = 0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               y, cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  int n_checks = 0, n_fail = 0;

  seq_detect_moore #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .a(a), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clear_cnt(clear_cnt), .y(y), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic e, input logic b);
    en = e; a = b;
    @(posedge clk); #1;
    en = 0; a = 0;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                      input logic o, input logic clr);
    cfg_load = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; clear_cnt = clr;
    @(posedge clk); #1;
    cfg_load = 0; clear_cnt = 0;
  endtask

  task automatic test_reset;
    logic [4:0] bits = 5'b10101;
    logic [4:0] ey   = 5'b00101;
    #1;
    n_checks++; if (y !== 1'b0 || match_cnt !== 2'd0 || cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_state y=%b cnt=%0d err=%b need 0/0/0", y, match_cnt, cfg_err);
    end
    @(posedge clk); #1; reset = 1;
    for (int i = 4; i >= 0; i--) begin
      drive(1, bits[i]);
      n_checks++; if (y !== ey[i]) begin
        n_fail++; $display("FAIL reset_default_y bit%0d y=%b need %b", 4-i, y, ey[i]);
      end
    end
    n_checks++; if (match_cnt !== 2'd2) begin
      n_fail++; $display("FAIL reset_default_cnt got %0d need 2", match_cnt);
    end
    reset = 0; #1;
    n_checks++; if (y !== 1'b0 || match_cnt !== 2'd0) begin
      n_fail++; $display("FAIL async_reset y=%b cnt=%0d need 0/0", y, match_cnt);
    end
    @(posedge clk); #1; reset = 1;
    drive(1, 0);
    reset = 0; #2; reset = 1;
    drive(1, 1);
    n_checks++; if (y !== 1'b0) begin
      n_fail++; $display("FAIL reset_midpattern y=%b need 0", y);
    end
  endtask

  task automatic test_overlap;
    logic [6:0] bits = 7'b1011011;
    logic [6:0] ey   = 7'b0001001;
    load(8'b1011, 4'd4, 1'b1, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      drive(1, bits[i]);
      n_checks++; if (y !== ey[i]) begin
        n_fail++; $display("FAIL overlap_y bit%0d y=%b need %b", 7-i, y, ey[i]);
      end
    end
    n_checks++; if (match_cnt !== 2'd2) begin
      n_fail++; $display("FAIL overlap_cnt got %0d need 2", match_cnt);
    end
  endtask

  task automatic test_nonoverlap;
    logic [6:0] bits = 7'b1011011;
    logic [6:0] ey   = 7'b0001000;
    load(8'b1011, 4'd4, 1'b0, 1'b0);
    n_checks++; if (match_cnt !== 2'd2) begin
      n_fail++; $display("FAIL load_keeps_cnt got %0d need 2", match_cnt);
    end
    load(8'b1011, 4'd4, 1'b0, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      drive(1, bits[i]);
      n_checks++; if (y !== ey[i]) begin
        n_fail++; $display("FAIL nonoverlap_y bit%0d y=%b need %b", 7-i, y, ey[i]);
      end
    end
    n_checks++; if (match_cnt !== 2'd1) begin
      n_fail++; $display("FAIL nonoverlap_cnt got %0d need 1", match_cnt);
    end
  endtask

  task automatic test_en_gating;
    load(8'b01, 4'd2, 1'b1, 1'b1);
    drive(1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1);
      n_checks++; if (y !== 1'b0) begin
        n_fail++; $display("FAIL en_stall_y cyc%0d y=%b need 0", i, y);
      end
    end
    drive(1, 1);
    n_checks++; if (y !== 1'b1) begin
      n_fail++; $display("FAIL en_accept_y y=%b need 1", y);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0);
      n_checks++; if (y !== 1'b1 || match_cnt !== 2'd1) begin
        n_fail++; $display("FAIL en_hold y=%b cnt=%0d need 1/1", y, match_cnt);
      end
    end
  endtask

  task automatic test_cfg_edges;
    logic [5:0] bits = 6'b010111;
    load(8'b01, 4'd0, 1'b1, 1'b1);
    n_checks++; if (cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL len0_err got %b need 1", cfg_err);
    end
    for (int i = 5; i >= 0; i--) begin
      drive(1, bits[i]);
      n_checks++; if (y !== 1'b0) begin
        n_fail++; $display("FAIL len0_nohit bit%0d y=%b need 0", 5-i, y);
      end
    end
    n_checks++; if (match_cnt !== 2'd0) begin
      n_fail++; $display("FAIL len0_cnt got %0d need 0", match_cnt);
    end
    load(8'b01, 4'd9, 1'b1, 1'b0);
    n_checks++; if (cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL len9_err got %b need 1", cfg_err);
    end
    load(8'hFF, 4'd8, 1'b1, 1'b0);
    n_checks++; if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL lenmax_err got %b need 0", cfg_err);
    end
    for (int i = 0; i < 7; i++) drive(1, 1);
    drive(1, 0);
    for (int i = 0; i < 7; i++) begin
      drive(1, 1);
      n_checks++; if (y !== 1'b0) begin
        n_fail++; $display("FAIL lenmax_early one%0d y=%b need 0", i+1, y);
      end
    end
    drive(1, 1);
    n_checks++; if (y !== 1'b1) begin
      n_fail++; $display("FAIL lenmax_hit y=%b need 1", y);
    end
    // Load with a bit present: that 0 must not count toward "01".
    en = 1; a = 0;
    load(8'b01, 4'd2, 1'b1, 1'b0);
    en = 0;
    n_checks++; if (y !== 1'b0) begin
      n_fail++; $display("FAIL load_clears_y y=%b need 0", y);
    end
    drive(1, 1);
    n_checks++; if (y !== 1'b0) begin
      n_fail++; $display("FAIL load_drops_bit y=%b need 0", y);
    end
    drive(1, 0);
    drive(1, 1);
    n_checks++; if (y !== 1'b1) begin
      n_fail++; $display("FAIL load_then_hit y=%b need 1", y);
    end
  endtask

  task automatic test_counter;
    logic [CNT_W-1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    load(8'b1, 4'd1, 1'b1, 1'b1);
    n_checks++; if (match_cnt !== 2'd0) begin
      n_fail++; $display("FAIL cnt_clear_on_load got %0d need 0", match_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 1);
      n_checks++; if (match_cnt !== ec[i] || y !== 1'b1) begin
        n_fail++; $display("FAIL cnt_sat hit%0d cnt=%0d y=%b need %0d/1", i+1, match_cnt, y, ec[i]);
      end
    end
    clear_cnt = 1;
    drive(1, 1);
    clear_cnt = 0;
    n_checks++; if (match_cnt !== 2'd1) begin
      n_fail++; $display("FAIL cnt_clear_with_hit got %0d need 1", match_cnt);
    end
    clear_cnt = 1;
    drive(0, 0);
    clear_cnt = 0;
    n_checks++; if (match_cnt !== 2'd0) begin
      n_fail++; $display("FAIL cnt_clear_alone got %0d need 0", match_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_overlap;
    test_nonoverlap;
    test_en_gating;
    test_cfg_edges;
    test_counter;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
